anim_frame_sequencer: RTL and testbench

ANIM_FRAME_SEQUENCER -- requirements
Module: anim_frame_sequencer

---
 rtl/anim_frame_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_anim_frame_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/anim_frame_sequencer.sv
// Sprite animation frame sequencer: prescaled tick drives loop,
// ping-pong, one-shot and hold playback over a per-animation frame count.
module anim_frame_sequencer #(
   parameter int N_ANIM  = 16,
   parameter int FRAME_W = 5,
   parameter int SPD_W   = 24,
   parameter logic [N_ANIM*FRAME_W-1:0] LIMIT_TABLE = {
      5'd4, 5'd2, 5'd2, 5'd2,
      5'd2, 5'd2, 5'd4, 5'd4,
      5'd2, 5'd6, 5'd6, 5'd6,
      5'd6, 5'd6, 5'd12, 5'd10
   },
   localparam int ANIM_W = (N_ANIM > 1) ? $clog2(N_ANIM) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [ANIM_W-1:0]  anim_sel,
   input  logic [1:0]         mode,
   input  logic [SPD_W-1:0]   speed,
   output logic [FRAME_W-1:0] frame,
   output logic [FRAME_W-1:0] limit,
   output logic               step,
   output logic               wrap,
   output logic               done
);

   localparam logic [1:0] M_LOOP = 2'b00;
   localparam logic [1:0] M_PING = 2'b01;
   localparam logic [1:0] M_ONE  = 2'b10;
   localparam logic [1:0] M_HOLD = 2'b11;

   typedef enum logic [1:0] {
      S_UP   = 2'd0,
      S_DOWN = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [ANIM_W-1:0]   anim_q, anim_d;
   logic [ANIM_W-1:0]   sel_eff;
   logic [FRAME_W-1:0]  frame_q, frame_d;
   logic [FRAME_W-1:0]  limit_q, limit_d;
   logic [SPD_W-1:0]    pre_q, pre_d;
   logic                step_q, step_d;
   logic                wrap_q, wrap_d;
   logic                change;
   logic                tick;
   logic                single;
   logic                at_top;
   logic                at_bot;

   // Table entries of zero behave as a one-frame animation.
   function automatic logic [FRAME_W-1:0] lim_of(
      input logic [ANIM_W-1:0] a
   );
      logic [FRAME_W-1:0] v;
      v = LIMIT_TABLE[a*FRAME_W +: FRAME_W];
      return (v == '0) ? FRAME_W'(1) : v;
   endfunction

   always_comb begin
      sel_eff = anim_sel;
      if (32'(anim_sel) >= N_ANIM) begin
         sel_eff = '0;
      end
   end

   assign change = (sel_eff != anim_q);
   assign tick   = en & (pre_q == '0);
   assign single = (limit_q == FRAME_W'(1));
   assign at_top = (frame_q >= limit_q - FRAME_W'(1));
   assign at_bot = (frame_q == '0);

   // Prescaler and animation select; a change restarts the prescaler.
   always_comb begin
      anim_d  = anim_q;
      limit_d = limit_q;
      pre_d   = pre_q;
      if (change) begin
         anim_d  = sel_eff;
         limit_d = lim_of(sel_eff);
         pre_d   = speed;
      end else if (en) begin
         if (tick) begin
            pre_d = speed;
         end else begin
            pre_d = pre_q - SPD_W'(1);
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_UP;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (change) begin
         state_d = S_UP;
      end else begin
         unique case (state_q)
            S_UP, S_DOWN: begin
               if (tick) begin
                  unique case (mode)
                     M_LOOP: state_d = S_UP;
                     M_ONE: begin
                        state_d = at_top ? S_DONE : S_UP;
                     end
                     M_PING: begin
                        if (single) begin
                           state_d = state_q;
                        end else if (state_q == S_UP) begin
                           state_d = at_top ? S_DOWN : S_UP;
                        end else begin
                           state_d = at_bot ? S_UP : S_DOWN;
                        end
                     end
                     M_HOLD: state_d = state_q;
                     default: state_d = state_q;
                  endcase
               end
            end
            S_DONE: begin
               if (mode != M_ONE) begin
                  state_d = S_UP;
               end
            end
            default: state_d = S_UP;
         endcase
      end
   end

   // Output logic: frame index and pulses for the coming cycle
   always_comb begin
      frame_d = frame_q;
      step_d  = 1'b0;
      wrap_d  = 1'b0;
      if (change) begin
         frame_d = '0;
      end else if (tick && !single &&
                   (state_q == S_UP || state_q == S_DOWN)) begin
         unique case (mode)
            M_LOOP: begin
               step_d = 1'b1;
               if (at_top) begin
                  frame_d = '0;
                  wrap_d  = 1'b1;
               end else begin
                  frame_d = frame_q + FRAME_W'(1);
               end
            end
            M_ONE: begin
               if (!at_top) begin
                  frame_d = frame_q + FRAME_W'(1);
                  step_d  = 1'b1;
               end
            end
            M_PING: begin
               step_d = 1'b1;
               if (state_q == S_UP) begin
                  if (at_top) begin
                     frame_d = frame_q - FRAME_W'(1);
                     wrap_d  = 1'b1;
                  end else begin
                     frame_d = frame_q + FRAME_W'(1);
                  end
               end else begin
                  if (at_bot) begin
                     frame_d = frame_q + FRAME_W'(1);
                     wrap_d  = 1'b1;
                  end else begin
                     frame_d = frame_q - FRAME_W'(1);
                  end
               end
            end
            M_HOLD: begin
               frame_d = frame_q;
            end
            default: begin
               frame_d = frame_q;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         anim_q  <= sel_eff;
         limit_q <= lim_of(sel_eff);
         pre_q   <= speed;
         frame_q <= '0;
         step_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         anim_q  <= anim_d;
         limit_q <= limit_d;
         pre_q   <= pre_d;
         frame_q <= frame_d;
         step_q  <= step_d;
         wrap_q  <= wrap_d;
      end
   end

   assign frame = frame_q;
   assign limit = limit_q;
   assign step  = step_q;
   assign wrap  = wrap_q;
   assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_anim_frame_sequencer.sv
// Scoreboard bench for anim_frame_sequencer: a behavioural player model
// queues expected outputs each cycle; a second instance has a zero entry.
module tb_anim_frame_sequencer;

   localparam int FW = 5;
   localparam int SW = 24;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic [3:0]    anim_sel;
   logic [1:0]    mode;
   logic [SW-1:0] speed;
   logic [FW-1:0] frame, limit, z_frame, z_limit;
   logic          step, wrap, done, z_step, z_wrap, z_done;

   always #5 clk = ~clk;

   anim_frame_sequencer u_dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .anim_sel (anim_sel),
      .mode     (mode),
      .speed    (speed),
      .frame    (frame),
      .limit    (limit),
      .step     (step),
      .wrap     (wrap),
      .done     (done)
   );

   anim_frame_sequencer #(
      .LIMIT_TABLE ({5'd4, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd4, 5'd4,
                     5'd2, 5'd6, 5'd6, 5'd6, 5'd6, 5'd6, 5'd12, 5'd0})
   ) u_z (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .anim_sel (anim_sel),
      .mode     (mode),
      .speed    (speed),
      .frame    (z_frame),
      .limit    (z_limit),
      .step     (z_step),
      .wrap     (z_wrap),
      .done     (z_done)
   );

   typedef struct packed {
      logic [FW-1:0] frame;
      logic [FW-1:0] limit;
      logic          step;
      logic          wrap;
      logic          done;
   } exp_t;

   exp_t exp_q[$];
   int   lt[16] = '{10, 12, 6, 6, 6, 6, 6, 2, 4, 4, 2, 2, 2, 2, 2, 4};
   int   n_checks = 0;
   int   n_errors = 0;

   int   m_anim = -1;
   int   m_frame, m_pre;
   bit   m_dir, m_done, m_step, m_wrap;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp,
                  $time);
      end
   endtask

   // Behavioural player: what the upcoming clock edge should produce.
   function automatic void model_step();
      bit t;
      int lim;
      m_step = 0;
      m_wrap = 0;
      if (rst || int'(anim_sel) != m_anim) begin
         m_anim  = int'(anim_sel);
         m_frame = 0;
         m_dir   = 0;
         m_done  = 0;
         m_pre   = int'(speed);
         return;
      end
      lim = lt[m_anim];
      t = en && (m_pre == 0);
      if (en) m_pre = t ? int'(speed) : m_pre - 1;
      if (m_done) begin
         if (mode != 2'b10) m_done = 0;
      end else if (t) begin
         case (mode)
            2'b00: begin
               m_dir = 0;
               if (lim > 1) begin
                  m_step = 1;
                  if (m_frame == lim - 1) begin
                     m_frame = 0;
                     m_wrap  = 1;
                  end else m_frame++;
               end
            end
            2'b01: begin
               if (lim > 1) begin
                  m_step = 1;
                  if (!m_dir) begin
                     if (m_frame == lim - 1) begin
                        m_frame--;
                        m_dir  = 1;
                        m_wrap = 1;
                     end else m_frame++;
                  end else begin
                     if (m_frame == 0) begin
                        m_frame = 1;
                        m_dir   = 0;
                        m_wrap  = 1;
                     end else m_frame--;
                  end
               end
            end
            2'b10: begin
               m_dir = 0;
               if (m_frame == lim - 1) m_done = 1;
               else begin
                  m_frame++;
                  m_step = 1;
               end
            end
            default: ;
         endcase
      end
   endfunction

   task automatic cyc();
      exp_t e;
      model_step();
      e.frame = FW'(m_frame);
      e.limit = FW'(lt[m_anim]);
      e.step  = m_step;
      e.wrap  = m_wrap;
      e.done  = m_done;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check("sb_empty", 0, 1);
      end else begin
         e = exp_q.pop_front();
         check("frame", 32'(frame), 32'(e.frame));
         check("limit", 32'(limit), 32'(e.limit));
         check("step",  32'(step),  32'(e.step));
         check("wrap",  32'(wrap),  32'(e.wrap));
         check("done",  32'(done),  32'(e.done));
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      int guard;
      rst = 1'b1; en = 1'b1; anim_sel = 4'd0; mode = 2'b00; speed = '0;
      run(2);
      check("rst_frame", 32'(frame), 0);
      check("rst_limit", 32'(limit), 10);
      rst = 1'b0;
      run(24);

      anim_sel = 4'd2; mode = 2'b01; speed = 24'd3;
      run(60);

      anim_sel = 4'd7; mode = 2'b10; speed = '0;
      run(6);
      check("os_frame", 32'(frame), 1);
      check("os_done",  32'(done), 1);
      mode = 2'b00;
      run(4);

      anim_sel = 4'd0; speed = 24'd2;
      guard = 0;
      while (!(m_pre == 0 && m_frame == 3 && m_anim == 0) && guard < 200) begin
         cyc();
         guard++;
      end
      check("chg_wait", 32'(guard < 200), 1);
      anim_sel = 4'd1;
      cyc();
      check("chg_frame", 32'(frame), 0);
      check("chg_limit", 32'(limit), 12);
      check("chg_step",  32'(step), 0);
      run(10);

      en = 1'b0;
      run(50);
      en = 1'b1; mode = 2'b11;
      run(20);
      mode = 2'b00;
      run(8);

      anim_sel = 4'd3; mode = 2'b01; speed = 24'd1;
      guard = 0;
      while (!(m_dir && m_frame == 3) && guard < 200) begin
         cyc();
         guard++;
      end
      check("dn_wait", 32'(guard < 200), 1);
      mode = 2'b00;
      run(12);
      mode = 2'b10;
      run(8);

      anim_sel = 4'd2; mode = 2'b01; speed = '0;
      guard = 0;
      while (!m_dir && guard < 200) begin
         cyc();
         guard++;
      end
      check("pp_wait", 32'(guard < 200), 1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("pp_rst_frame", 32'(frame), 0);
      check("pp_rst_done",  32'(done), 0);
      run(4);

      mode = 2'b10;
      guard = 0;
      while (!m_done && guard < 200) begin
         cyc();
         guard++;
      end
      check("os_wait", 32'(guard < 200), 1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("os_rst_frame", 32'(frame), 0);
      check("os_rst_done",  32'(done), 0);
      run(4);

      for (int i = 0; i < 400; i++) begin
         en = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 29) == 0) anim_sel = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 19) == 0) speed = SW'($urandom_range(0, 3));
         rst = ($urandom_range(0, 99) == 0);
         cyc();
      end

      rst = 1'b1; en = 1'b1; anim_sel = 4'd0; mode = 2'b00; speed = '0;
      cyc();
      rst = 1'b0;
      run(3);
      check("z_limit", 32'(z_limit), 1);
      check("z_frame", 32'(z_frame), 0);
      check("z_step",  32'(z_step), 0);
      check("z_wrap",  32'(z_wrap), 0);
      mode = 2'b01;
      run(3);
      check("z_pp_frame", 32'(z_frame), 0);
      check("z_pp_wrap",  32'(z_wrap), 0);
      check("z_pp_done",  32'(z_done), 0);
      mode = 2'b10;
      run(1);
      check("z_os_done",  32'(z_done), 1);
      check("z_os_frame", 32'(z_frame), 0);
      check("z_os_step",  32'(z_step), 0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
